// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller with PC, credit-based issue, fetch FIFO and redirect/fault handling
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;
    logic          fault_q, fault_d;
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   occ;
    logic          redirect, pop, push, credit, issue;

    function automatic logic legal(input logic [31:0] a);
        return a[1:0] == 2'b00 && a < 32'(IMEM_WORDS * 4);
    endfunction

    assign redirect    = redirect_valid && state_q != BOOT;
    assign out_valid   = count_q != '0;
    assign pop         = out_valid && out_ready && !redirect;
    assign push        = inflight_q && !drop_q && !redirect;
    assign occ         = 32'(count_q) + 32'(inflight_q);
    assign credit      = occ < 32'(FIFO_DEPTH) + 32'(out_valid && out_ready);
    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign out_instr   = out_valid ? instr_mem_q[rd_q] : 32'h0;
    assign out_pc      = out_valid ? pc_mem_q[rd_q] : 32'h0;
    assign fetch_fault = fault_q;

    // next-state: redirect wins, BOOT lasts one cycle, FETCH issues while credit remains and PC is legal
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        issue      = 1'b0;
        inflight_d = 1'b0;
        drop_d     = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc;
            fault_d = !legal(redirect_pc);
            state_d = legal(redirect_pc) ? FETCH : FAULT;
            drop_d  = inflight_q;
        end else if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (state_q == FETCH && credit) begin
            if (legal(pc_q)) begin
                issue      = 1'b1;
                pc_d       = pc_q + 32'd4;
                inflight_d = 1'b1;
            end else begin
                fault_d = 1'b1;
                state_d = FAULT;
            end
        end
    end

    // control registers and FIFO pointers; redirect flushes the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            fault_q    <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= issue ? pc_q : req_pc_q;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
            rd_q       <= redirect ? '0 : rd_q + PW'(pop);
            wr_q       <= redirect ? '0 : wr_q + PW'(push);
            count_q    <= redirect ? '0 : count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_q] <= imem_rdata;
            pc_mem_q[wr_q]    <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table-driven and sequence checks for fetch_ctrl
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(256), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return (32'(i) << 20) | (32'(i) << 7) | 32'h13;
    endfunction

    // instruction memory: one-cycle read latency
    always @(posedge clk) if (imem_req) imem_rdata <= word(int'(imem_addr[9:2]));

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic rd, logic rq, logic [31:0] a, logic v,
                                logic [31:0] p, logic [31:0] ins, logic f);
        vec_t t;
        t.rst_n = r; t.rdy = rd; t.req = rq; t.addr = a;
        t.valid = v; t.pc = p; t.instr = ins; t.fault = f;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        // startup, streaming
        tbl.push_back(mk(1, 1, 0, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h04, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h08, 1, 32'h00, 32'h00000013, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0C, 1, 32'h04, 32'h00100093, 0));
        tbl.push_back(mk(1, 1, 1, 32'h10, 1, 32'h08, 32'h00200113, 0));
        tbl.push_back(mk(1, 1, 1, 32'h14, 1, 32'h0C, 32'h00300193, 0));
        tbl.push_back(mk(0, 1, 0, 32'h00, 0, 0, 0, 0));
        // backpressure from cycle 3
        tbl.push_back(mk(1, 1, 0, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h04, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h08, 1, 32'h00, 32'h00000013, 0));
        tbl.push_back(mk(1, 0, 0, 32'h08, 1, 32'h00, 32'h00000013, 0));
        tbl.push_back(mk(1, 0, 0, 32'h08, 1, 32'h00, 32'h00000013, 0));
        tbl.push_back(mk(1, 1, 1, 32'h08, 1, 32'h00, 32'h00000013, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0C, 1, 32'h04, 32'h00100093, 0));
        tbl.push_back(mk(1, 0, 0, 32'h10, 1, 32'h08, 32'h00200113, 0));
        tbl.push_back(mk(1, 0, 0, 32'h10, 1, 32'h08, 32'h00200113, 0));
        // reset with two buffered entries, then restart from RESET_PC
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h04, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h08, 1, 32'h00, 32'h00000013, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n     = tbl[i].rst_n;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
            chk($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'(tbl[i].fault));
            if (tbl[i].valid) begin
                chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].pc);
                chk($sformatf("row%0d out_instr", i), out_instr, tbl[i].instr);
            end
        end

        // redirect with one buffered entry and one response in flight
        cyc(1, 1, 32'h40);
        chk("rdr40 no issue", 32'(imem_req), 32'h0);
        cyc(1, 0, 32'h0);
        chk("rdr40 req", 32'(imem_req), 32'h1);
        chk("rdr40 addr", imem_addr, 32'h40);
        chk("rdr40 flushed", 32'(out_valid), 32'h0);
        cyc(1, 0, 32'h0);
        chk("rdr40 addr2", imem_addr, 32'h44);
        chk("rdr40 stale dropped", 32'(out_valid), 32'h0);
        cyc(1, 0, 32'h0);
        chk("rdr40 valid", 32'(out_valid), 32'h1);
        chk("rdr40 pc", out_pc, 32'h40);
        chk("rdr40 instr", out_instr, word(16));
        cyc(1, 0, 32'h0);
        chk("rdr40 pc2", out_pc, 32'h44);

        // misaligned redirect faults, legal redirect recovers
        cyc(1, 1, 32'h42);
        chk("rdr42 no issue", 32'(imem_req), 32'h0);
        cyc(1, 0, 32'h0);
        chk("rdr42 fault", 32'(fetch_fault), 32'h1);
        chk("rdr42 req", 32'(imem_req), 32'h0);
        chk("rdr42 flushed", 32'(out_valid), 32'h0);
        cyc(1, 0, 32'h0);
        chk("fault hold req", 32'(imem_req), 32'h0);
        chk("fault hold flag", 32'(fetch_fault), 32'h1);
        cyc(1, 1, 32'h10);
        chk("rdr10 no issue", 32'(imem_req), 32'h0);
        cyc(1, 0, 32'h0);
        chk("rdr10 fault clr", 32'(fetch_fault), 32'h0);
        chk("rdr10 req", 32'(imem_req), 32'h1);
        chk("rdr10 addr", imem_addr, 32'h10);
        cyc(1, 0, 32'h0);
        chk("rdr10 addr2", imem_addr, 32'h14);
        cyc(1, 0, 32'h0);
        chk("rdr10 pc", out_pc, 32'h10);
        chk("rdr10 instr", out_instr, word(4));

        // run off the end of instruction memory
        cyc(1, 1, 32'h3F8);
        cyc(1, 0, 32'h0);
        chk("end req 3f8", 32'(imem_req), 32'h1);
        chk("end addr 3f8", imem_addr, 32'h3F8);
        cyc(1, 0, 32'h0);
        chk("end addr 3fc", imem_addr, 32'h3FC);
        cyc(1, 0, 32'h0);
        chk("end no req 400", 32'(imem_req), 32'h0);
        chk("end pc 3f8", out_pc, 32'h3F8);
        chk("end fault early", 32'(fetch_fault), 32'h0);
        cyc(1, 0, 32'h0);
        chk("end fault", 32'(fetch_fault), 32'h1);
        chk("end req off", 32'(imem_req), 32'h0);
        chk("end valid 3fc", 32'(out_valid), 32'h1);
        chk("end pc 3fc", out_pc, 32'h3FC);
        chk("end instr 3fc", out_instr, word(255));
        cyc(1, 0, 32'h0);
        chk("end drained", 32'(out_valid), 32'h0);
        chk("end still off", 32'(imem_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
